stonyman_scan_ctrl: RTL and testbench

Raster scan sequencer for the Stonyman imager path. It walks the 112x112 pixel array in row-major order and presents each coordinate to the frame mask stage. It samples that stage's `is_valid` verdict and issues a pixel-capture handshake only for unmasked pixels. It sits directly upstream of the frame mask, which consumes `current_row`/`current_col`, and drives the ADC/readout logic through `px_req`/`px_ack`.

---
 rtl/stonyman_pkg.sv | 18 +
 rtl/raster_counter.sv | 35 +++
 rtl/stonyman_scan_ctrl.sv | 122 ++++++++++++
 tb/tb_stonyman_scan_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stonyman_pkg.sv
// Shared constants and FSM state encoding for the Stonyman raster scan path.
package stonyman_pkg;

  localparam int ROWS  = 112;
  localparam int COLS  = 112;
  localparam int RC_W  = 7;
  localparam int CNT_W = 14;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_CHECK  = 3'd2,
    S_REQ    = 3'd3,
    S_ADV    = 3'd4,
    S_DONE   = 3'd5
  } scan_state_t;

endpackage

// File: rtl/raster_counter.sv
// Row-major row/column counter with synchronous clear, advance and last-pixel flag.
module raster_counter #(
  parameter int ROWS = 112,
  parameter int COLS = 112,
  parameter int RC_W = 7
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear,
  input  logic            advance,
  output logic [RC_W-1:0] row,
  output logic [RC_W-1:0] col,
  output logic            last
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col == RC_W'(COLS - 1)) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign last = (row == RC_W'(ROWS - 1)) && (col == RC_W'(COLS - 1));

endmodule

// File: rtl/stonyman_scan_ctrl.sv
// Raster scan sequencer: walks the pixel array and requests captures for unmasked pixels.
// Build option STONYMAN_MASK_EN: when defined, is_valid gates requests; otherwise every pixel is requested.
module stonyman_scan_ctrl #(
  parameter int ROWS  = stonyman_pkg::ROWS,
  parameter int COLS  = stonyman_pkg::COLS,
  parameter int RC_W  = stonyman_pkg::RC_W,
  parameter int CNT_W = stonyman_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  output logic [RC_W-1:0]  current_row,
  output logic [RC_W-1:0]  current_col,
  input  logic             is_valid,
  output logic             px_req,
  input  logic             px_ack,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] px_count
);
  import stonyman_pkg::*;

  // state | meaning
  // IDLE   | waiting for start
  // SETTLE | mask lookup resolving for the new coordinate
  // CHECK  | sample the mask verdict
  // REQ    | capture request outstanding until px_ack
  // ADV    | step to next pixel or finish
  // DONE   | frame complete pulse
  localparam logic [2:0] ST_IDLE   = S_IDLE;
  localparam logic [2:0] ST_SETTLE = S_SETTLE;
  localparam logic [2:0] ST_CHECK  = S_CHECK;
  localparam logic [2:0] ST_REQ    = S_REQ;
  localparam logic [2:0] ST_ADV    = S_ADV;
  localparam logic [2:0] ST_DONE   = S_DONE;

  logic [2:0] state, nxt;
  logic       clear, advance, inc, count_clr, last, valid;

`ifdef STONYMAN_MASK_EN
  assign valid = is_valid;
`else
  logic unused_is_valid;
  assign unused_is_valid = is_valid;
  assign valid = 1'b1;
`endif

  raster_counter #(
    .ROWS (ROWS),
    .COLS (COLS),
    .RC_W (RC_W)
  ) u_raster (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .advance (advance),
    .row     (current_row),
    .col     (current_col),
    .last    (last)
  );

  assign count_clr = (state == ST_IDLE) && start && !abort;

  always_comb begin
    nxt     = state;
    clear   = 1'b0;
    advance = 1'b0;
    inc     = 1'b0;
    case (state)
      ST_IDLE:   if (start && !abort) begin
                   nxt   = ST_SETTLE;
                   clear = 1'b1;
                 end
      ST_SETTLE: nxt = ST_CHECK;
      ST_CHECK:  nxt = valid ? ST_REQ : ST_ADV;
      ST_REQ:    if (px_ack) begin
                   nxt = ST_ADV;
                   inc = 1'b1;
                 end
      ST_ADV:    if (last) begin
                   nxt = ST_DONE;
                 end else begin
                   nxt     = ST_SETTLE;
                   advance = 1'b1;
                 end
      ST_DONE:   begin
                   nxt   = ST_IDLE;
                   clear = 1'b1;
                 end
      default:   nxt = ST_IDLE;
    endcase
    // Abort overrides everything, including an ack landing in the same cycle.
    if (abort && (state != ST_IDLE)) begin
      nxt     = ST_IDLE;
      clear   = 1'b1;
      advance = 1'b0;
      inc     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      px_req     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      px_count   <= '0;
    end else begin
      state      <= nxt;
      px_req     <= (nxt == ST_REQ);
      busy       <= (nxt != ST_IDLE);
      frame_done <= (nxt == ST_DONE);
      if (count_clr) begin
        px_count <= '0;
      end else if (inc && (px_count != {CNT_W{1'b1}})) begin
        px_count <= px_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stonyman_scan_ctrl.sv
// Directed self-checking bench for stonyman_scan_ctrl (expectations adapt to STONYMAN_MASK_EN).
module tb_stonyman_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [6:0]  current_row;
  logic [6:0]  current_col;
  logic        is_valid;
  logic        px_req;
  logic        px_ack;
  logic        busy;
  logic        frame_done;
  logic [13:0] px_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ack_mode  = 1;   // 0 never ack, 1 tied high, 2 ack after ack_delay REQ cycles
  int ack_delay = 5;
  int req_len   = 0;
  int mask_mode = 0;   // 0 all valid, 1 all masked, 2 valid only at (0,111) and (1,0)

  stonyman_scan_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .current_row (current_row),
    .current_col (current_col),
    .is_valid    (is_valid),
    .px_req      (px_req),
    .px_ack      (px_ack),
    .busy        (busy),
    .frame_done  (frame_done),
    .px_count    (px_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    is_valid = 1'b0;
    case (mask_mode)
      0: is_valid = 1'b1;
      1: is_valid = 1'b0;
      default: is_valid = ((current_row == 7'd0) && (current_col == 7'd111)) ||
                          ((current_row == 7'd1) && (current_col == 7'd0));
    endcase
  end

  initial begin
    px_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (px_req) req_len = req_len + 1;
      else req_len = 0;
      case (ack_mode)
        1: px_ack = 1'b1;
        2: px_ack = px_req && (req_len >= ack_delay);
        default: px_ack = 1'b0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic abort_now();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({current_row, current_col, px_req, busy, frame_done, px_count} !== 31'd0) begin
      errors++;
      $display("FAIL reset_values got row=%0d col=%0d req=%b busy=%b done=%b cnt=%0d want all 0",
               current_row, current_col, px_req, busy, frame_done, px_count);
    end
    #2 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_full_frame();
    mask_mode = 0;
    ack_mode = 1;
    start_frame();
    checks++;
    if (!(busy === 1'b1 && current_row === 7'd0 && current_col === 7'd0)) begin
      errors++;
      $display("FAIL first_cycle got busy=%b row=%0d col=%0d want 1 0 0", busy, current_row, current_col);
    end
    while (frame_done !== 1'b1 && cyc < 60000) tick();
    checks++;
    if (cyc !== 50177) begin
      errors++;
      $display("FAIL full_frame_done_cycle got %0d want 50177", cyc);
    end
    checks++;
    if (px_count !== 14'd12544) begin
      errors++;
      $display("FAIL full_frame_count got %0d want 12544", px_count);
    end
    tick();
    checks++;
    if (!(frame_done === 1'b0 && busy === 1'b0 && current_row === 7'd0 &&
          current_col === 7'd0 && px_count === 14'd12544)) begin
      errors++;
      $display("FAIL after_done got done=%b busy=%b row=%0d col=%0d cnt=%0d want 0 0 0 0 12544",
               frame_done, busy, current_row, current_col, px_count);
    end
  endtask

  task automatic test_all_masked();
    int reqs;
    reqs = 0;
    mask_mode = 1;
    ack_mode = 0;
    start_frame();
`ifdef STONYMAN_MASK_EN
    while (frame_done !== 1'b1 && cyc < 40000) begin
      tick();
      if (px_req === 1'b1) reqs++;
    end
    checks++;
    if (cyc !== 37633) begin
      errors++;
      $display("FAIL masked_done_cycle got %0d want 37633", cyc);
    end
    checks++;
    if (reqs !== 0 || px_count !== 14'd0) begin
      errors++;
      $display("FAIL masked_no_req got reqs=%0d cnt=%0d want 0 0", reqs, px_count);
    end
    tick();
`else
    tick();
    tick();
    checks++;
    if (px_req !== 1'b1 || cyc !== 3) begin
      errors++;
      $display("FAIL mask_ignored_req got req=%b at cycle %0d want 1 at 3", px_req, cyc);
    end
    abort_now();
`endif
  endtask

  task automatic test_sparse_wrap();
    int reqs, bad_len, run, guard;
    logic [6:0] prow, pcol;
    logic wrap_seen;
    reqs = 0; bad_len = 0; run = 0; guard = 0; wrap_seen = 1'b0;
    mask_mode = 2;
    ack_mode = 2;
    ack_delay = 5;
    start_frame();
    prow = current_row;
    pcol = current_col;
    while (!(current_row == 7'd1 && current_col == 7'd1) && guard < 2000) begin
      tick();
      guard++;
      if (px_req === 1'b1) run++;
      else if (run > 0) begin
        reqs++;
        if (run != 5) bad_len++;
        run = 0;
      end
      if (pcol == 7'd111 && current_col == 7'd0) begin
        wrap_seen = 1'b1;
        checks++;
        if (prow !== 7'd0 || current_row !== 7'd1) begin
          errors++;
          $display("FAIL row_wrap got row %0d->%0d want 0->1", prow, current_row);
        end
      end
      prow = current_row;
      pcol = current_col;
    end
    checks++;
    if (guard >= 2000 || wrap_seen !== 1'b1) begin
      errors++;
      $display("FAIL sparse_progress got guard=%0d wrap=%b want reach (1,1) with wrap", guard, wrap_seen);
    end
`ifdef STONYMAN_MASK_EN
    checks++;
    if (reqs !== 2 || px_count !== 14'd2) begin
      errors++;
      $display("FAIL sparse_reqs got reqs=%0d cnt=%0d want 2 2", reqs, px_count);
    end
`else
    checks++;
    if (reqs !== 113 || px_count !== 14'd113) begin
      errors++;
      $display("FAIL sparse_reqs got reqs=%0d cnt=%0d want 113 113", reqs, px_count);
    end
`endif
    checks++;
    if (bad_len !== 0) begin
      errors++;
      $display("FAIL req_hold got %0d requests not 5 cycles want 0", bad_len);
    end
    abort_now();
  endtask

  task automatic test_abort_in_req();
    mask_mode = 0;
    ack_mode = 1;
    start_frame();
    while (!(px_req === 1'b1 && px_count === 14'd100) && cyc < 1000) tick();
    checks++;
    if (cyc !== 403) begin
      errors++;
      $display("FAIL abort_point_cycle got %0d want 403", cyc);
    end
    abort_now();
    checks++;
    if (!(busy === 1'b0 && px_req === 1'b0 && frame_done === 1'b0 && px_count === 14'd100 &&
          current_row === 7'd0 && current_col === 7'd0)) begin
      errors++;
      $display("FAIL abort_req got busy=%b req=%b done=%b cnt=%0d row=%0d col=%0d want 0 0 0 100 0 0",
               busy, px_req, frame_done, px_count, current_row, current_col);
    end
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || px_count !== 14'd100) begin
      errors++;
      $display("FAIL start_abort_idle got busy=%b cnt=%0d want 0 100", busy, px_count);
    end
  endtask

  task automatic test_start_while_busy();
    mask_mode = 0;
    ack_mode = 1;
    start_frame();
    while (cyc < 10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (!(busy === 1'b1 && current_row === 7'd0 && current_col === 7'd2)) begin
      errors++;
      $display("FAIL start_busy_c12 got busy=%b row=%0d col=%0d want 1 0 2", busy, current_row, current_col);
    end
    tick();
    checks++;
    if (current_col !== 7'd3 || px_count !== 14'd3) begin
      errors++;
      $display("FAIL start_busy_c13 got col=%0d cnt=%0d want 3 3", current_col, px_count);
    end
    abort_now();
  endtask

  task automatic test_reset_mid_frame();
    mask_mode = 0;
    ack_mode = 0;
    start_frame();
    while (px_req !== 1'b1 && cyc < 20) tick();
    checks++;
    if (cyc !== 3) begin
      errors++;
      $display("FAIL req_before_reset got cycle %0d want 3", cyc);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({current_row, current_col, px_req, busy, frame_done, px_count} !== 31'd0) begin
      errors++;
      $display("FAIL async_reset got row=%0d col=%0d req=%b busy=%b done=%b cnt=%0d want all 0",
               current_row, current_col, px_req, busy, frame_done, px_count);
    end
    reset_n = 1'b1;
    ack_mode = 1;
    tick();
    start_frame();
    checks++;
    if (!(busy === 1'b1 && current_row === 7'd0 && current_col === 7'd0)) begin
      errors++;
      $display("FAIL restart_origin got busy=%b row=%0d col=%0d want 1 0 0", busy, current_row, current_col);
    end
    repeat (4) tick();
    checks++;
    if (current_col !== 7'd1 || px_count !== 14'd1) begin
      errors++;
      $display("FAIL restart_step got col=%0d cnt=%0d want 1 1", current_col, px_count);
    end
    abort_now();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_all_masked();
    test_sparse_wrap();
    test_abort_in_req();
    test_start_abort_idle();
    test_start_while_busy();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
